// File: rtl/obi_rule_demux.sv
//------------------------------------------------------------------------------
// Module   : obi_rule_demux
// Brief    : OBI 1-to-N rule-table address demux with in-order responses,
//            run-time reprogrammable rules and an internal error responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package obi_rule_demux_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

module obi_rule_demux
    import obi_rule_demux_pkg::*;
#(
    parameter int                          NSLAVE          = 6,
    parameter int                          NRULES          = 6,
    parameter int                          MAX_OUTSTANDING = 2,
    parameter int                          DEFAULT_EN      = 0,
    parameter int                          DEFAULT_IDX     = 2,
    parameter addr_map_rule_t [NRULES-1:0] RULES_INIT      = '0,
    parameter logic [31:0]                 ERR_RDATA       = 32'hBADACCE5,
    localparam int                         c_cfg_w         = (NRULES > 1) ? $clog2(NRULES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m_req_i,
    output logic                  m_gnt_o,
    input  logic [31:0]           m_addr_i,
    input  logic                  m_we_i,
    input  logic [3:0]            m_be_i,
    input  logic [31:0]           m_wdata_i,
    output logic                  m_rvalid_o,
    output logic [31:0]           m_rdata_o,
    output logic                  m_err_o,

    output logic [NSLAVE-1:0]     s_req_o,
    input  logic [NSLAVE-1:0]     s_gnt_i,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_wdata_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    input  logic [NSLAVE-1:0]     s_rvalid_i,
    input  logic [NSLAVE*32-1:0]  s_rdata_i,

    input  logic                  cfg_req_i,
    output logic                  cfg_gnt_o,
    input  logic [c_cfg_w-1:0]    cfg_rule_i,
    input  logic [31:0]           cfg_start_i,
    input  logic [31:0]           cfg_end_i,
    input  logic [31:0]           cfg_idx_i
);

    localparam int c_tgt_w = $clog2(NSLAVE + 1);
    localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    // Target code NSLAVE stands for the internal error responder.
    localparam logic [c_tgt_w-1:0] c_err_tgt = c_tgt_w'(NSLAVE);
    localparam logic [c_tgt_w-1:0] c_def_tgt = c_tgt_w'(DEFAULT_IDX);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_OUTSTANDING);

    addr_map_rule_t [NRULES-1:0] r_rules;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [c_tgt_w-1:0]          r_last_tgt;
    logic                        r_err_pend;

    logic [c_tgt_w-1:0]          w_tgt;
    logic                        w_hit;
    logic                        w_busy;
    logic                        w_stall;
    logic                        w_hs;
    logic                        w_rvalid;
    logic                        w_from_err;
    logic [31:0]                 w_sel_rdata;

    // Lowest-numbered valid rule wins; empty ranges and bad indices are skipped.
    always_comb begin
        w_tgt = (DEFAULT_EN != 0) ? c_def_tgt : c_err_tgt;
        w_hit = 1'b0;
        for (int k = 0; k < NRULES; k++) begin
            if (!w_hit && (r_rules[k].start_addr <= m_addr_i) &&
                (m_addr_i < r_rules[k].end_addr) && (r_rules[k].idx < 32'(NSLAVE))) begin
                w_hit = 1'b1;
                w_tgt = r_rules[k].idx[c_tgt_w-1:0];
            end
        end
    end

    assign w_busy  = (r_cnt != '0);
    assign w_stall = (r_cnt == c_max_cnt) | (w_busy & (w_tgt != r_last_tgt));

    always_comb begin
        s_req_o = '0;
        m_gnt_o = 1'b0;
        if (!rst_i && !w_stall) begin
            if (w_tgt == c_err_tgt) begin
                m_gnt_o = m_req_i;
            end else begin
                for (int i = 0; i < NSLAVE; i++) begin
                    if (w_tgt == c_tgt_w'(i)) begin
                        s_req_o[i] = m_req_i;
                        m_gnt_o    = s_gnt_i[i];
                    end
                end
            end
        end
    end

    assign w_hs      = m_req_i & m_gnt_o;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;

    // Only the slave that owns the outstanding requests may answer.
    always_comb begin
        w_rvalid    = 1'b0;
        w_sel_rdata = '0;
        if (r_last_tgt == c_err_tgt) begin
            w_rvalid = r_err_pend;
        end else begin
            for (int i = 0; i < NSLAVE; i++) begin
                if (r_last_tgt == c_tgt_w'(i)) begin
                    w_rvalid    = s_rvalid_i[i] & w_busy;
                    w_sel_rdata = s_rdata_i[i*32 +: 32];
                end
            end
        end
    end

    assign w_from_err = (r_last_tgt == c_err_tgt);
    assign m_rvalid_o = w_rvalid & ~rst_i;
    assign m_err_o    = m_rvalid_o & w_from_err;
    assign m_rdata_o  = !m_rvalid_o ? 32'h0 : (w_from_err ? ERR_RDATA : w_sel_rdata);
    assign cfg_gnt_o  = cfg_req_i & ~w_busy & ~m_req_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rules    <= RULES_INIT;
            r_cnt      <= '0;
            r_last_tgt <= '0;
            r_err_pend <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_tgt <= w_tgt;
            end
            r_err_pend <= w_hs & (w_tgt == c_err_tgt);
            case ({w_hs, m_rvalid_o})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (cfg_gnt_o && ({1'b0, cfg_rule_i} < (c_cfg_w + 1)'(NRULES))) begin
                r_rules[cfg_rule_i] <= '{idx: cfg_idx_i, start_addr: cfg_start_i, end_addr: cfg_end_i};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_obi_rule_demux.sv
//------------------------------------------------------------------------------
// Module   : tb_obi_rule_demux
// Brief    : Self-checking bench for obi_rule_demux (directed + random).
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_obi_rule_demux;
    import obi_rule_demux_pkg::*;

    localparam int NS   = 6;
    localparam int NR   = 6;
    localparam int MAXO = 2;
    localparam logic [31:0] ERRD = 32'hBADACCE5;
    localparam addr_map_rule_t [NR-1:0] SYS_MAP = {
        {32'd5, 32'hF000_0000, 32'hF001_0000},
        {32'd4, 32'h8000_0000, 32'h9000_0000},
        {32'd3, 32'hF010_0000, 32'hF020_0000},
        {32'd2, 32'h1000_0000, 32'h2000_0000},
        {32'd1, 32'hF001_0000, 32'hF002_0000},
        {32'd0, 32'h0000_0000, 32'h0010_0000}};

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m_req_i, m_we_i;
    logic [31:0]       m_addr_i, m_wdata_i;
    logic [3:0]        m_be_i;
    logic              m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0]       m_rdata_o;
    logic [NS-1:0]     s_req_o, s_gnt_i, s_rvalid_i;
    logic [31:0]       s_addr_o, s_wdata_o;
    logic              s_we_o;
    logic [3:0]        s_be_o;
    logic [NS*32-1:0]  s_rdata_i;
    logic              cfg_req_i, cfg_gnt_o;
    logic [2:0]        cfg_rule_i;
    logic [31:0]       cfg_start_i, cfg_end_i, cfg_idx_i;

    logic              d_m_gnt, d_m_rvalid, d_m_err, d_s_we, d_cfg_gnt;
    logic [31:0]       d_m_rdata, d_s_addr, d_s_wdata;
    logic [NS-1:0]     d_s_req;
    logic [3:0]        d_s_be;

    int total = 0;
    int bad   = 0;
    int q[$];

    always #5 clk_i = ~clk_i;

    obi_rule_demux #(.NSLAVE(NS), .NRULES(NR), .MAX_OUTSTANDING(MAXO), .DEFAULT_EN(0),
                     .DEFAULT_IDX(2), .RULES_INIT(SYS_MAP), .ERR_RDATA(ERRD)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rule_i(cfg_rule_i),
        .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_idx_i(cfg_idx_i));

    obi_rule_demux #(.NSLAVE(NS), .NRULES(NR), .MAX_OUTSTANDING(MAXO), .DEFAULT_EN(1),
                     .DEFAULT_IDX(2), .RULES_INIT(SYS_MAP), .ERR_RDATA(ERRD)) u_dut_def (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_gnt_o(d_m_gnt), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(d_m_rvalid),
        .m_rdata_o(d_m_rdata), .m_err_o(d_m_err),
        .s_req_o(d_s_req), .s_gnt_i(s_gnt_i), .s_addr_o(d_s_addr), .s_wdata_o(d_s_wdata),
        .s_we_o(d_s_we), .s_be_o(d_s_be), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(d_cfg_gnt), .cfg_rule_i(cfg_rule_i),
        .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_idx_i(cfg_idx_i));

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic idle();
        m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_be_i = 4'hF;
        s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
        cfg_req_i = 1'b0; cfg_rule_i = '0; cfg_start_i = '0; cfg_end_i = '0; cfg_idx_i = '0;
    endtask

    // Reference decode: first rule whose half-open range holds the address and
    // whose slave exists; otherwise the error responder (code NS).
    function automatic int ref_decode(input logic [31:0] a);
        for (int k = 0; k < NR; k++) begin
            if (SYS_MAP[k].start_addr <= a && a < SYS_MAP[k].end_addr && SYS_MAP[k].idx < NS)
                return int'(SYS_MAP[k].idx);
        end
        return NS;
    endfunction

    task automatic test_reset();
        cyc(); idle(); rst_i = 1'b1;
        m_req_i = 1'b1; m_addr_i = 32'hF010_0010; s_gnt_i = '1; s_rvalid_i = '1;
        s_rdata_i = {6{32'hFFFF_FFFF}}; cfg_req_i = 1'b1;
        #1;
        total++; if (m_rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", m_rvalid_o); end
        total++; if (m_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", m_rdata_o); end
        total++; if (m_err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", m_err_o); end
        total++; if (s_req_o !== '0) begin bad++; $display("FAIL rst_sreq: got %b want 0", s_req_o); end
        total++; if (cfg_gnt_o !== 1'b0) begin bad++; $display("FAIL rst_cfg_gnt: got %b want 0", cfg_gnt_o); end
        cyc(); idle(); rst_i = 1'b0; #1;
        total++; if (u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", u_dut.r_cnt); end
        total++; if (u_dut.r_rules !== SYS_MAP) begin bad++; $display("FAIL rst_rules: got %h want %h", u_dut.r_rules, SYS_MAP); end
    endtask

    task automatic test_slave_read();
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hF010_0010; m_be_i = 4'h3; #1;
        total++; if (s_req_o !== 6'b001000) begin bad++; $display("FAIL rd_sreq: got %b want 001000", s_req_o); end
        total++; if (m_gnt_o !== 1'b0) begin bad++; $display("FAIL rd_nogrant: got %b want 0", m_gnt_o); end
        total++; if (s_addr_o !== 32'hF010_0010 || s_be_o !== 4'h3) begin bad++; $display("FAIL rd_passthru: got %h/%h want F0100010/3", s_addr_o, s_be_o); end
        cyc(); s_gnt_i[3] = 1'b1; #1;
        total++; if (m_gnt_o !== 1'b1) begin bad++; $display("FAIL rd_gnt: got %b want 1", m_gnt_o); end
        cyc(); idle(); s_rvalid_i[3] = 1'b1; s_rdata_i[3*32 +: 32] = 32'h1234_5678;
        s_rvalid_i[1] = 1'b1; s_rdata_i[1*32 +: 32] = 32'hDEAD_0001; #1;
        total++; if (m_rvalid_o !== 1'b1 || m_rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp: got %b/%h want 1/12345678", m_rvalid_o, m_rdata_o); end
        total++; if (m_err_o !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", m_err_o); end
        cyc(); idle(); s_rvalid_i[3] = 1'b1; s_rdata_i[3*32 +: 32] = 32'h5555_AAAA; #1;
        total++; if (m_rvalid_o !== 1'b0 || m_rdata_o !== 32'h0) begin bad++; $display("FAIL rd_after: got %b/%h want 0/0", m_rvalid_o, m_rdata_o); end
        total++; if (u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL rd_cnt: got %0d want 0", u_dut.r_cnt); end
    endtask

    task automatic test_err_default();
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hE000_0000; m_we_i = 1'b1; m_wdata_i = 32'hCAFE_F00D; #1;
        total++; if (m_gnt_o !== 1'b1) begin bad++; $display("FAIL err_gnt: got %b want 1", m_gnt_o); end
        total++; if (s_req_o !== '0) begin bad++; $display("FAIL err_sreq: got %b want 0", s_req_o); end
        total++; if (s_wdata_o !== 32'hCAFE_F00D || s_we_o !== 1'b1) begin bad++; $display("FAIL err_wpass: got %h/%b want CAFEF00D/1", s_wdata_o, s_we_o); end
        total++; if (d_s_req !== 6'b000100 || d_m_gnt !== 1'b0) begin bad++; $display("FAIL def_sreq: got %b/%b want 000100/0", d_s_req, d_m_gnt); end
        cyc(); idle(); #1;
        total++; if (m_rvalid_o !== 1'b1 || m_rdata_o !== ERRD || m_err_o !== 1'b1) begin bad++; $display("FAIL err_resp: got %b/%h/%b want 1/%h/1", m_rvalid_o, m_rdata_o, m_err_o, ERRD); end
        cyc(); idle(); #1;
        total++; if (m_rvalid_o !== 1'b0 || m_err_o !== 1'b0 || m_rdata_o !== 32'h0) begin bad++; $display("FAIL err_after: got %b/%b/%h want 0/0/0", m_rvalid_o, m_err_o, m_rdata_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); m_req_i = (i < 3); m_addr_i = 32'h9000_0000; #1;
            total++; if (m_gnt_o !== (i < 3)) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", i, m_gnt_o, (i < 3)); end
            total++; if (m_rvalid_o !== (i > 0) || m_err_o !== (i > 0)) begin bad++; $display("FAIL b2b_resp%0d: got %b/%b want %b", i, m_rvalid_o, m_err_o, (i > 0)); end
        end
        cyc(); idle(); #1;
        total++; if (m_rvalid_o !== 1'b0 || u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL b2b_end: got %b/%0d want 0/0", m_rvalid_o, u_dut.r_cnt); end
    endtask

    task automatic test_switch_stall();
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hF010_0010; s_gnt_i[3] = 1'b1; #1;
        total++; if (m_gnt_o !== 1'b1) begin bad++; $display("FAIL sw_gnt3: got %b want 1", m_gnt_o); end
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hF001_0000; s_gnt_i = '1; #1;
            total++; if (m_gnt_o !== 1'b0 || s_req_o !== '0) begin bad++; $display("FAIL sw_stall%0d: got %b/%b want 0/0", i, m_gnt_o, s_req_o); end
        end
        cyc(); s_rvalid_i[3] = 1'b1; s_rdata_i[3*32 +: 32] = 32'h0BAD_F00D; #1;
        total++; if (m_gnt_o !== 1'b0 || m_rvalid_o !== 1'b1 || m_rdata_o !== 32'h0BAD_F00D) begin bad++; $display("FAIL sw_resp3: got %b/%b/%h want 0/1/0BADF00D", m_gnt_o, m_rvalid_o, m_rdata_o); end
        cyc(); s_rvalid_i = '0; #1;
        total++; if (m_gnt_o !== 1'b1 || s_req_o !== 6'b000010) begin bad++; $display("FAIL sw_gnt1: got %b/%b want 1/000010", m_gnt_o, s_req_o); end
        cyc(); idle(); s_rvalid_i = 6'b001010; s_rdata_i[1*32 +: 32] = 32'h1111_2222; #1;
        total++; if (m_rvalid_o !== 1'b1 || m_rdata_o !== 32'h1111_2222) begin bad++; $display("FAIL sw_resp1: got %b/%h want 1/11112222", m_rvalid_o, m_rdata_o); end
        cyc(); idle(); #1;
        total++; if (u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL sw_cnt: got %0d want 0", u_dut.r_cnt); end
    endtask

    task automatic test_max_outstanding();
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'h8000_0000; s_gnt_i[4] = 1'b1; #1;
            total++; if (m_gnt_o !== 1'b1) begin bad++; $display("FAIL mo_gnt%0d: got %b want 1", i, m_gnt_o); end
        end
        cyc(); #1;
        total++; if (m_gnt_o !== 1'b0 || s_req_o !== '0) begin bad++; $display("FAIL mo_stall: got %b/%b want 0/0", m_gnt_o, s_req_o); end
        total++; if (u_dut.r_cnt !== 2'd2) begin bad++; $display("FAIL mo_cnt2: got %0d want 2", u_dut.r_cnt); end
        cyc(); s_rvalid_i[4] = 1'b1; #1;
        total++; if (m_gnt_o !== 1'b0 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL mo_full_rv: got %b/%b want 0/1", m_gnt_o, m_rvalid_o); end
        cyc(); #1;
        total++; if (m_gnt_o !== 1'b1 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL mo_both: got %b/%b want 1/1", m_gnt_o, m_rvalid_o); end
        cyc(); s_rvalid_i = '0; #1;
        total++; if (u_dut.r_cnt !== 2'd1) begin bad++; $display("FAIL mo_hold: got %0d want 1", u_dut.r_cnt); end
        cyc(); idle(); s_rvalid_i[4] = 1'b1; #1;
        total++; if (u_dut.r_cnt !== 2'd2 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL mo_drain: got %0d/%b want 2/1", u_dut.r_cnt, m_rvalid_o); end
        cyc(); #1;
        cyc(); idle(); #1;
        total++; if (u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL mo_end: got %0d want 0", u_dut.r_cnt); end
    endtask

    task automatic test_config();
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hA000_0004;
        cfg_req_i = 1'b1; cfg_rule_i = 3'd3; cfg_idx_i = 32'd4; cfg_start_i = 32'hA000_0000; cfg_end_i = 32'hA000_1000; #1;
        total++; if (m_gnt_o !== 1'b1 || s_req_o !== '0 || cfg_gnt_o !== 1'b0) begin bad++; $display("FAIL cfg_prio: got %b/%b/%b want 1/0/0", m_gnt_o, s_req_o, cfg_gnt_o); end
        cyc(); m_req_i = 1'b0; #1;
        total++; if (cfg_gnt_o !== 1'b0 || m_err_o !== 1'b1) begin bad++; $display("FAIL cfg_busy_err: got %b/%b want 0/1", cfg_gnt_o, m_err_o); end
        cyc(); #1;
        total++; if (cfg_gnt_o !== 1'b1) begin bad++; $display("FAIL cfg_gnt: got %b want 1", cfg_gnt_o); end
        cyc(); cfg_req_i = 1'b0; m_req_i = 1'b1; m_addr_i = 32'hA000_0004; #1;
        total++; if (s_req_o !== 6'b010000 || m_gnt_o !== 1'b0) begin bad++; $display("FAIL cfg_new_rule: got %b/%b want 010000/0", s_req_o, m_gnt_o); end
        cyc(); s_gnt_i[4] = 1'b1; #1;
        cyc(); idle(); cfg_req_i = 1'b1; cfg_rule_i = 3'd5; cfg_idx_i = 32'd7; cfg_start_i = 32'hC000_0000; cfg_end_i = 32'hC000_1000; #1;
        total++; if (cfg_gnt_o !== 1'b0) begin bad++; $display("FAIL cfg_cnt1: got %b want 0", cfg_gnt_o); end
        cyc(); s_rvalid_i[4] = 1'b1; #1;
        total++; if (cfg_gnt_o !== 1'b0 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL cfg_cnt1_rv: got %b/%b want 0/1", cfg_gnt_o, m_rvalid_o); end
        cyc(); s_rvalid_i = '0; #1;
        total++; if (cfg_gnt_o !== 1'b1) begin bad++; $display("FAIL cfg_gnt5: got %b want 1", cfg_gnt_o); end
        cyc(); cfg_rule_i = 3'd4; cfg_idx_i = 32'd4; cfg_start_i = 32'h8000_0000; cfg_end_i = 32'h8000_0000; #1;
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hC000_0010; s_gnt_i = '1; #1;
        total++; if (m_gnt_o !== 1'b1 || s_req_o !== '0) begin bad++; $display("FAIL cfg_badidx: got %b/%b want 1/0", m_gnt_o, s_req_o); end
        cyc(); m_addr_i = 32'h8000_0000; #1;
        total++; if (m_gnt_o !== 1'b1 || s_req_o !== '0 || m_err_o !== 1'b1) begin bad++; $display("FAIL cfg_empty: got %b/%b/%b want 1/0/1", m_gnt_o, s_req_o, m_err_o); end
        cyc(); idle(); #1;
        cyc(); idle(); #1;
        total++; if (u_dut.r_cnt !== 2'd0 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL cfg_end: got %0d/%b want 0/0", u_dut.r_cnt, m_rvalid_o); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hA000_0010; s_gnt_i[4] = 1'b1; #1;
        end
        cyc(); idle(); rst_i = 1'b1; s_rvalid_i[4] = 1'b1; s_rdata_i[4*32 +: 32] = 32'h7777_7777; #1;
        total++; if (u_dut.r_cnt !== 2'd2 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL rmf_pre: got %0d/%b want 2/0", u_dut.r_cnt, m_rvalid_o); end
        cyc(); rst_i = 1'b0; #1;
        total++; if (m_rvalid_o !== 1'b0 || m_rdata_o !== 32'h0 || s_req_o !== '0) begin bad++; $display("FAIL rmf_late: got %b/%h/%b want 0/0/0", m_rvalid_o, m_rdata_o, s_req_o); end
        total++; if (u_dut.r_cnt !== 2'd0) begin bad++; $display("FAIL rmf_cnt: got %0d want 0", u_dut.r_cnt); end
        total++; if (u_dut.r_rules !== SYS_MAP) begin bad++; $display("FAIL rmf_rules: got %h want %h", u_dut.r_rules, SYS_MAP); end
        cyc(); idle(); m_req_i = 1'b1; m_addr_i = 32'hE000_0000; #1;
        cyc(); idle(); rst_i = 1'b1; #1;
        total++; if (m_rvalid_o !== 1'b0 || m_err_o !== 1'b0) begin bad++; $display("FAIL rmf_errgate: got %b/%b want 0/0", m_rvalid_o, m_err_o); end
        cyc(); rst_i = 1'b0; m_req_i = 1'b1; m_addr_i = 32'hF010_0010; #1;
        total++; if (m_rvalid_o !== 1'b0 || m_err_o !== 1'b0 || s_req_o !== 6'b001000) begin bad++; $display("FAIL rmf_after: got %b/%b/%b want 0/0/001000", m_rvalid_o, m_err_o, s_req_o); end
        cyc(); idle(); #1;
    endtask

    task automatic rand_cycle(input bit drain);
        logic [31:0] pool [10];
        logic [NS-1:0] esreq;
        logic [31:0] erd;
        logic egnt, erv, eerr, ecfg;
        int tgt, pick;
        pool = '{32'hF010_0010, 32'hF001_0000, 32'h0000_0100, 32'h1FFF_FFFC, 32'h8FFF_FFFC,
                 32'h9000_0000, 32'hF000_FFFC, 32'hE000_0000, 32'hF020_0000, 32'h0010_0000};
        cyc();
        if (drain) begin
            idle(); s_rvalid_i = '1;
        end else begin
            m_req_i   = ($urandom_range(0, 3) != 0);
            pick      = $urandom_range(0, 10);
            m_addr_i  = (pick == 10) ? $urandom : pool[pick];
            m_we_i    = 1'($urandom); m_be_i = 4'($urandom); m_wdata_i = $urandom;
            s_gnt_i   = NS'($urandom); s_rvalid_i = NS'($urandom);
            cfg_req_i = ($urandom_range(0, 3) == 0);
            cfg_rule_i = 3'($urandom);
            if (cfg_rule_i < NR) begin
                cfg_idx_i = SYS_MAP[cfg_rule_i].idx; cfg_start_i = SYS_MAP[cfg_rule_i].start_addr; cfg_end_i = SYS_MAP[cfg_rule_i].end_addr;
            end else begin
                cfg_idx_i = 32'd0; cfg_start_i = 32'h0; cfg_end_i = 32'hFFFF_FFFF;
            end
        end
        for (int i = 0; i < NS; i++) s_rdata_i[i*32 +: 32] = $urandom;
        #1;
        tgt = ref_decode(m_addr_i);
        esreq = '0; egnt = 1'b0; erv = 1'b0; eerr = 1'b0; erd = 32'h0;
        if (q.size() < MAXO && (q.size() == 0 || q[$] == tgt)) begin
            if (tgt == NS) egnt = m_req_i;
            else begin esreq[tgt] = m_req_i; egnt = s_gnt_i[tgt]; end
        end
        if (q.size() != 0) begin
            if (q[0] == NS) begin erv = 1'b1; eerr = 1'b1; erd = ERRD; end
            else if (s_rvalid_i[q[0]]) begin erv = 1'b1; erd = s_rdata_i[q[0]*32 +: 32]; end
        end
        ecfg = cfg_req_i && (q.size() == 0) && !m_req_i;
        total++; if (s_req_o !== esreq) begin bad++; $display("FAIL rnd_sreq: got %b want %b addr %h", s_req_o, esreq, m_addr_i); end
        total++; if (m_gnt_o !== egnt) begin bad++; $display("FAIL rnd_gnt: got %b want %b addr %h", m_gnt_o, egnt, m_addr_i); end
        total++; if (m_rvalid_o !== erv || m_rdata_o !== erd || m_err_o !== eerr) begin bad++; $display("FAIL rnd_resp: got %b/%h/%b want %b/%h/%b", m_rvalid_o, m_rdata_o, m_err_o, erv, erd, eerr); end
        total++; if (cfg_gnt_o !== ecfg) begin bad++; $display("FAIL rnd_cfg: got %b want %b", cfg_gnt_o, ecfg); end
        total++; if (s_addr_o !== m_addr_i) begin bad++; $display("FAIL rnd_addr: got %h want %h", s_addr_o, m_addr_i); end
        if (erv) void'(q.pop_front());
        if (m_req_i && egnt) q.push_back(tgt);
    endtask

    task automatic test_random();
        q.delete();
        for (int n = 0; n < 2000; n++) rand_cycle(1'b0);
        for (int n = 0; n < 4; n++) rand_cycle(1'b1);
        cyc(); idle(); #1;
        total++; if (int'(u_dut.r_cnt) !== q.size()) begin bad++; $display("FAIL rnd_cnt: got %0d want %0d", u_dut.r_cnt, q.size()); end
    endtask

    initial begin
        idle(); rst_i = 1'b1;
        repeat (2) cyc();
        test_reset();
        test_slave_read();
        test_err_default();
        test_back_to_back();
        test_switch_stall();
        test_max_outstanding();
        test_config();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
